scope_capture_ctrl: RTL

Capture controller for the oscilloscope sample path. It takes the 12-bit samples already moved into this clock domain, detects a trigger crossing, and writes a pre-trigger/post-trigger window into a circular sample RAM by driving its write port. When the window is complete it reports the trigger location to the Nios II. The CPU then reads the RAM starting at `rd_base`.

---
 rtl/scope_capture_ctrl_if.sv | 37 +++
 rtl/scope_capture_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/scope_capture_ctrl_if.sv
// Capture controller bus: CPU control, sample stream,
// RAM write port and status back to the CPU.
interface scope_capture_ctrl_if #(
    parameter int N = 12,
    parameter int A = 10
);
    logic         start;
    logic         abort;
    logic         force_trig;
    logic         sample_valid;
    logic [N-1:0] sample;
    logic [N-1:0] trig_level;
    logic         trig_slope;
    logic [A-1:0] pretrig_len;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [N-1:0] wr_data;
    logic         busy;
    logic         done;
    logic [A-1:0] trig_addr;
    logic [A-1:0] rd_base;
    logic [2:0]   state;

    modport master (
        output start, abort, force_trig, sample_valid, sample,
        output trig_level, trig_slope, pretrig_len,
        input  wr_en, wr_addr, wr_data, busy, done,
        input  trig_addr, rd_base, state
    );

    modport slave (
        input  start, abort, force_trig, sample_valid, sample,
        input  trig_level, trig_slope, pretrig_len,
        output wr_en, wr_addr, wr_data, busy, done,
        output trig_addr, rd_base, state
    );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Scope capture controller: pre/post-trigger window
// written into a circular sample RAM.
module scope_capture_ctrl #(
    parameter int N = 12,
    parameter int A = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    scope_capture_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] ptr_q, ptr_d;
    logic [A-1:0] cnt_q, cnt_d;
    logic [N-1:0] prev_q, prev_d;
    logic         prev_vld_q, prev_vld_d;
    logic         force_q, force_d;
    logic [N-1:0] level_q, level_d;
    logic         slope_q, slope_d;
    logic [A-1:0] plen_q, plen_d;
    logic         wr_en_q, wr_en_d;
    logic [A-1:0] wr_addr_q, wr_addr_d;
    logic [N-1:0] wr_data_q, wr_data_d;
    logic [A-1:0] trig_addr_q, trig_addr_d;
    logic [A-1:0] rd_base_q, rd_base_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic accept;
    logic hit;
    logic trig;

    // Sample acceptance and level-crossing detection
    always_comb begin
        accept = bus.sample_valid && !bus.abort &&
                 (state_q == S_FILL || state_q == S_ARMED ||
                  state_q == S_POST);
        if (slope_q)
            hit = (prev_q > level_q) && (bus.sample <= level_q);
        else
            hit = (prev_q < level_q) && (bus.sample >= level_q);
        trig = accept && (state_q == S_ARMED) &&
               (force_q || bus.force_trig || (prev_vld_q && hit));
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        force_d     = force_q;
        level_d     = level_q;
        slope_d     = slope_q;
        plen_d      = plen_q;
        wr_en_d     = accept;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        trig_addr_d = trig_addr_q;
        rd_base_d   = rd_base_q;

        if (accept) begin
            wr_addr_d  = ptr_q;
            wr_data_d  = bus.sample;
            ptr_d      = ptr_q + A'(1);
            prev_d     = bus.sample;
            prev_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    level_d    = bus.trig_level;
                    slope_d    = bus.trig_slope;
                    plen_d     = bus.pretrig_len;
                    ptr_d      = '0;
                    cnt_d      = '0;
                    prev_vld_d = 1'b0;
                    force_d    = 1'b0;
                    state_d    = (bus.pretrig_len != '0) ? S_FILL : S_ARMED;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (cnt_q + A'(1) == plen_q)
                        state_d = S_ARMED;
                    else
                        cnt_d = cnt_q + A'(1);
                end
            end
            S_ARMED: begin
                if (bus.force_trig && !accept)
                    force_d = 1'b1;
                if (trig) begin
                    trig_addr_d = ptr_q;
                    rd_base_d   = ptr_q - plen_q;
                    cnt_d       = ~plen_q;
                    force_d     = 1'b0;
                    state_d     = (~plen_q == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (accept) begin
                    if (cnt_q == A'(1))
                        state_d = S_DONE;
                    else
                        cnt_d = cnt_q - A'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort)
            state_d = S_IDLE;

        busy_d = (state_d == S_FILL) || (state_d == S_ARMED) ||
                 (state_d == S_POST);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            force_q     <= 1'b0;
            level_q     <= '0;
            slope_q     <= 1'b0;
            plen_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_addr_q <= '0;
            rd_base_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            force_q     <= force_d;
            level_q     <= level_d;
            slope_q     <= slope_d;
            plen_q      <= plen_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            trig_addr_q <= trig_addr_d;
            rd_base_q   <= rd_base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.trig_addr = trig_addr_q;
    assign bus.rd_base   = rd_base_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;
endmodule
